// File: rtl/scroll_pkg.sv
// scroll_pkg: shared definitions for the seven-segment message scroller.
//   - MODE_* : encodings of the 2-bit mode input (2'b11 also behaves as pause)
//   - SEG_OFF: all segments dark (active-low)
//   - seg_of : hex character -> active-low {a,b,c,d,e,f,g,dp}, dp always off
package scroll_pkg;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_PAUSE  = 2'b10;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] seg_of(input logic [3:0] ch);
        logic [7:0] s;
        case (ch)
            4'h0:    s = 8'b0000_0011;
            4'h1:    s = 8'b1001_1111;
            4'h2:    s = 8'b0010_0101;
            4'h3:    s = 8'b0000_1101;
            4'h4:    s = 8'b1001_1001;
            4'h5:    s = 8'b0100_1001;
            4'h6:    s = 8'b0100_0001;
            4'h7:    s = 8'b0001_1111;
            4'h8:    s = 8'b0000_0001;
            4'h9:    s = 8'b0000_1001;
            4'hA:    s = 8'b0001_0001;
            4'hB:    s = 8'b1100_0001;
            4'hC:    s = 8'b0110_0011;
            4'hD:    s = 8'b1000_0101;
            4'hE:    s = 8'b0110_0001;
            default: s = 8'b0111_0001;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/step_debouncer.sv
// step_debouncer: synchronises a raw pushbutton, debounces it and emits a
// one-cycle pulse on each accepted press (0->1 of the debounced level).
//   clk        : clock
//   reset      : asynchronous active-high reset
//   btn_raw    : raw asynchronous button
//   step_pulse : one-cycle pulse, registered
module step_debouncer #(
    parameter int DEBOUNCE_TICKS = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          pulse_q;
    logic          btn_s;

    assign btn_s      = sync_q[1];
    assign step_pulse = pulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            pulse_q <= 1'b0;
            if (btn_s == level_q) begin
                // Input agrees with the accepted level: restart the stability window.
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                cnt_q   <= '0;
                level_q <= btn_s;
                pulse_q <= btn_s;   // only a rising acceptance is a step
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/scroll_display.sv
// scroll_display: multi-digit seven-segment message scroller.
// Holds MSG_DEPTH hex characters, multiplexes a NUM_DIGITS window onto a
// common-anode display and moves the window automatically, on a debounced
// button press, or not at all.
//   clk, reset          : clock, asynchronous active-high reset
//   mode, dir           : scroll mode (AUTO/MANUAL/PAUSE) and direction
//   step_btn            : raw button for MANUAL stepping
//   wr_en/wr_addr/wr_data : character buffer write port
//   an, seg             : active-low anodes and segments (registered)
//   ptr                 : current window start
module scroll_display
    import scroll_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MSG_DEPTH      = 16,
    parameter int SCROLL_TICKS   = 16_000_000,
    parameter int REFRESH_TICKS  = 10_000,
    parameter int DEBOUNCE_TICKS = 100_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         dir,
    input  logic                         step_btn,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [3:0]                   wr_data,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [7:0]                   seg,
    output logic [$clog2(MSG_DEPTH)-1:0] ptr
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int KW = $clog2(NUM_DIGITS);
    localparam int SW = (SCROLL_TICKS > 1)  ? $clog2(SCROLL_TICKS)  : 1;
    localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

    // Reset asserts immediately, releases two clock edges later.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic step_pulse;

    step_debouncer #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
        .clk        (clk),
        .reset      (rst_int),
        .btn_raw    (step_btn),
        .step_pulse (step_pulse)
    );

    logic [1:0]            mode_q;
    logic [SW-1:0]         scnt_q, scnt_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [RW-1:0]         rcnt_q, rcnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  lit_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q;
    logic [3:0]            buf_q [MSG_DEPTH];
    logic                  do_step;
    logic [AW:0]           off, sum;
    logic [AW-1:0]         idx;

    // Scroll counter and pointer.
    always_comb begin
        scnt_d  = scnt_q;
        do_step = 1'b0;
        if (mode != mode_q) begin
            scnt_d = '0;    // mode change restarts the scroll period
        end else if (mode == MODE_AUTO) begin
            if (scnt_q == SW'(SCROLL_TICKS - 1)) begin
                scnt_d  = '0;
                do_step = 1'b1;
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end else if (mode == MODE_MANUAL) begin
            scnt_d = '0;
        end
        // Pulses outside MANUAL are dropped here.
        if (mode == MODE_MANUAL && step_pulse) do_step = 1'b1;

        ptr_d = ptr_q;
        if (do_step) begin
            if (dir) ptr_d = (ptr_q == '0) ? AW'(MSG_DEPTH - 1) : ptr_q - AW'(1);
            else     ptr_d = (ptr_q == AW'(MSG_DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    // Refresh counter and digit index.
    always_comb begin
        rcnt_d = rcnt_q + RW'(1);
        k_d    = k_q;
        if (rcnt_q == RW'(REFRESH_TICKS - 1)) begin
            rcnt_d = '0;
            k_d    = (k_q == KW'(NUM_DIGITS - 1)) ? '0 : k_q + KW'(1);
        end
    end

    // Character index for digit k: ptr + (NUM_DIGITS-1-k), wrapped by compare
    // so a non-power-of-two depth works.
    always_comb begin
        off = (AW+1)'(NUM_DIGITS - 1) - (AW+1)'(k_q);
        sum = {1'b0, ptr_q} + off;
        if (sum >= (AW+1)'(MSG_DEPTH)) idx = AW'(sum - (AW+1)'(MSG_DEPTH));
        else                           idx = AW'(sum);
        an_d = ~(NUM_DIGITS'(1) << k_q);
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            mode_q <= MODE_AUTO;
            scnt_q <= '0;
            ptr_q  <= '0;
            rcnt_q <= '0;
            k_q    <= '0;
            lit_q  <= 1'b0;
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            for (int i = 0; i < MSG_DEPTH; i++) buf_q[i] <= 4'(i % 16);
        end else begin
            mode_q <= mode;
            scnt_q <= scnt_d;
            ptr_q  <= ptr_d;
            rcnt_q <= rcnt_d;
            k_q    <= k_d;
            // Display stays dark for the first cycle after release.
            lit_q  <= 1'b1;
            if (lit_q) begin
                an_q  <= an_d;
                seg_q <= seg_of(buf_q[idx]);
            end
            if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_DEPTH)))
                buf_q[wr_addr] <= wr_data;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign ptr = ptr_q;

endmodule

// File: tb/tb_scroll_display.sv
module tb_scroll_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic       step_btn = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] ptr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scroll_display #(
        .NUM_DIGITS(4), .MSG_DEPTH(16), .SCROLL_TICKS(8),
        .REFRESH_TICKS(2), .DEBOUNCE_TICKS(4)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .dir(dir), .step_btn(step_btn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .an(an), .seg(seg), .ptr(ptr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ptr changes or the bound runs out; n = cycles taken.
    task automatic wait_ptr(output int n, input int bound);
        logic [3:0] p;
        p = ptr;
        n = 0;
        while (ptr === p && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset_auto();
        int n, lit_at;
        logic [3:0] first_an;
        bit seen;
        reset = 1'b1; mode = 2'b00; dir = 1'b0;
        repeat (3) tick();
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h want ff", seg); end
        checks++; if (ptr !== 4'd0) begin failures++; $display("FAIL reset_ptr: got %0d want 0", ptr); end
        reset = 1'b0;
        n = 0; lit_at = 0; first_an = 4'b1111; seen = 0;
        while (ptr === 4'd0 && n < 40) begin
            tick();
            n++;
            if (lit_at == 0 && an !== 4'b1111) begin lit_at = n; first_an = an; end
            if (ptr === 4'd0 && an === 4'b0111 && !seen) begin
                seen = 1;
                checks++; if (seg !== 8'b0000_0011) begin failures++; $display("FAIL digit3_char0: got %b want 00000011", seg); end
            end
        end
        // 2 synchroniser edges + 8 scroll ticks
        checks++; if (n != 10) begin failures++; $display("FAIL first_step_time: got %0d want 10", n); end
        checks++; if (ptr !== 4'd1) begin failures++; $display("FAIL first_step_ptr: got %0d want 1", ptr); end
        checks++; if (lit_at != 4) begin failures++; $display("FAIL first_lit_time: got %0d want 4", lit_at); end
        checks++; if (first_an !== 4'b1110) begin failures++; $display("FAIL first_lit_an: got %b want 1110", first_an); end
        checks++; if (!seen) begin failures++; $display("FAIL digit3_seen: got 0 want 1"); end
        wait_ptr(n, 40);
        checks++; if (n != 8) begin failures++; $display("FAIL second_step_time: got %0d want 8", n); end
        checks++; if (ptr !== 4'd2) begin failures++; $display("FAIL second_step_ptr: got %0d want 2", ptr); end
    endtask

    task automatic test_wrap_dir();
        int n, k;
        k = 0;
        while (ptr !== 4'd15 && k < 20) begin wait_ptr(n, 20); k++; end
        checks++; if (ptr !== 4'd15) begin failures++; $display("FAIL reach15: got %0d want 15", ptr); end
        wait_ptr(n, 20);
        checks++; if (n != 8 || ptr !== 4'd0) begin failures++; $display("FAIL wrap_up: got ptr %0d after %0d want 0 after 8", ptr, n); end
        dir = 1'b1;
        wait_ptr(n, 20);
        checks++; if (n != 8 || ptr !== 4'd15) begin failures++; $display("FAIL wrap_down: got ptr %0d after %0d want 15 after 8", ptr, n); end
        wait_ptr(n, 20);
        checks++; if (n != 8 || ptr !== 4'd14) begin failures++; $display("FAIL down_step: got ptr %0d after %0d want 14 after 8", ptr, n); end
    endtask

    task automatic test_manual();
        int at, changes;
        logic [3:0] p;
        dir = 1'b0; mode = 2'b01;
        step_btn = 1'b1; repeat (3) tick(); step_btn = 1'b0;
        repeat (20) tick();
        checks++; if (ptr !== 4'd14) begin failures++; $display("FAIL glitch_ignored: got %0d want 14", ptr); end
        step_btn = 1'b1; at = 0; changes = 0;
        for (int i = 1; i <= 20; i++) begin
            p = ptr; tick();
            if (ptr !== p) begin changes++; if (at == 0) at = i; end
        end
        step_btn = 1'b0; repeat (20) tick();
        // 2 sync + 4 debounce + 1 pulse register
        checks++; if (at != 7) begin failures++; $display("FAIL press_latency: got %0d want 7", at); end
        checks++; if (changes != 1 || ptr !== 4'd15) begin failures++; $display("FAIL press_once: got %0d steps ptr %0d want 1 steps ptr 15", changes, ptr); end
        step_btn = 1'b1; changes = 0;
        for (int i = 0; i < 100; i++) begin
            p = ptr; tick();
            if (ptr !== p) changes++;
        end
        step_btn = 1'b0; repeat (20) tick();
        checks++; if (changes != 1 || ptr !== 4'd0) begin failures++; $display("FAIL hold_once: got %0d steps ptr %0d want 1 steps ptr 0", changes, ptr); end
    endtask

    task automatic test_write();
        bit seen;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'hE; tick(); wr_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (an === 4'b1011 && !seen) begin
                seen = 1;
                checks++; if (seg !== 8'b0110_0001) begin failures++; $display("FAIL write_E: got %b want 01100001", seg); end
            end
        end
        checks++; if (!seen || ptr !== 4'd0) begin failures++; $display("FAIL write_E_seen: got seen %0d ptr %0d want 1 0", seen, ptr); end
        // Entering AUTO registers on the first edge, step lands 8 edges later.
        mode = 2'b00; dir = 1'b1;
        repeat (8) tick();
        checks++; if (ptr !== 4'd0) begin failures++; $display("FAIL step_not_early: got %0d want 0", ptr); end
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 4'h8; tick(); wr_en = 1'b0;
        checks++; if (ptr !== 4'd15) begin failures++; $display("FAIL write_step_ptr: got %0d want 15", ptr); end
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (ptr === 4'd15 && an === 4'b0111 && !seen) begin
                seen = 1;
                checks++; if (seg !== 8'b0000_0001) begin failures++; $display("FAIL write_step_data: got %b want 00000001", seg); end
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL write_step_seen: got 0 want 1"); end
    endtask

    task automatic test_pause();
        int n, moved, trans, bad;
        logic [3:0] p, prev, exp_p;
        mode = 2'b10; p = ptr; prev = an; moved = 0; trans = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ptr !== p) moved++;
            if (an !== prev) begin
                trans++;
                if (an !== {prev[2:0], prev[3]}) bad++;
                prev = an;
            end
        end
        checks++; if (moved != 0) begin failures++; $display("FAIL pause_hold: got %0d moves want 0", moved); end
        checks++; if (bad != 0) begin failures++; $display("FAIL pause_an_order: got %0d bad want 0", bad); end
        checks++; if (trans != 25) begin failures++; $display("FAIL pause_an_rate: got %0d want 25", trans); end
        exp_p = (p == 4'd0) ? 4'd15 : p - 4'd1;
        mode = 2'b00;
        wait_ptr(n, 30);
        checks++; if (n != 9) begin failures++; $display("FAIL resume_time: got %0d want 9", n); end
        checks++; if (ptr !== exp_p) begin failures++; $display("FAIL resume_ptr: got %0d want %0d", ptr, exp_p); end
    endtask

    task automatic test_reset_mid();
        int n, k;
        bit seen;
        k = 0;
        while (ptr !== 4'd5 && k < 20) begin wait_ptr(n, 20); k++; end
        checks++; if (ptr !== 4'd5) begin failures++; $display("FAIL reach5: got %0d want 5", ptr); end
        repeat (3) tick();
        reset = 1'b1; #1;
        checks++; if (an !== 4'b1111) begin failures++; $display("FAIL midreset_an: got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL midreset_seg: got %h want ff", seg); end
        checks++; if (ptr !== 4'd0) begin failures++; $display("FAIL midreset_ptr: got %0d want 0", ptr); end
        mode = 2'b00; dir = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ptr === 4'd0 && an === 4'b1011 && !seen) begin
                seen = 1;
                checks++; if (seg !== 8'b1001_1111) begin failures++; $display("FAIL buf_restored: got %b want 10011111", seg); end
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL buf_restored_seen: got 0 want 1"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_auto();
        test_wrap_dir();
        test_manual();
        test_write();
        test_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
